// File: rtl/jt51_pkg.sv
// -----------------------------------------------------------------------------
// jt51_pkg
// Shared definitions for the noise-generator control slice.
//   noise_state_e  : write-sequencer states (idle / pending commit / busy hold)
//   NOISE_REG_ADDR : register address carrying NE and NFRQ
//   NE_BIT         : position of the noise-enable bit in the register data
//   NFRQ_MSB       : top bit of the noise-frequency field (field is [NFRQ_MSB:0])
//   SLOTS          : number of operator slots per frame
//   LAST_SLOT      : slot index that closes a frame
// -----------------------------------------------------------------------------
package jt51_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } noise_state_e;

    localparam logic [7:0] NOISE_REG_ADDR = 8'h0F;
    localparam int         NE_BIT         = 7;
    localparam int         NFRQ_MSB       = 4;
    localparam int         SLOTS          = 32;
    localparam logic [4:0] LAST_SLOT      = 5'(SLOTS - 1);

endpackage

// File: rtl/jt51_busy_timer.sv
// -----------------------------------------------------------------------------
// jt51_busy_timer
// Down-counter that times how long the write interface stays busy after a
// commit. Load has priority over decrement; the count never goes below zero.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   load_i       : load load_val_i into the counter
//   dec_i        : decrement by one (ignored when already zero)
//   load_val_i   : value loaded on load_i
//   zero_o       : counter currently holds zero
// -----------------------------------------------------------------------------
module jt51_busy_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/jt51_noise_ctrl.sv
// -----------------------------------------------------------------------------
// jt51_noise_ctrl
// Sequencer and configuration controller for the noise generator.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   cen         : clock enable; slot counter and output path advance on it
//   wr_req      : CPU write strobe (one clk wide, not qualified by cen)
//   wr_addr     : register address of the write
//   wr_data     : register data, bit7 = NE, bits4:0 = NFRQ
//   busy        : a noise-register write is in flight; new ones are dropped
//   wr_drop     : sticky flag, a noise-register write was dropped while busy
//   cycles      : 5-bit slot counter for the noise generator
//   nfrq, ne    : committed noise frequency / enable
//   op31_no     : one-cen strobe in the period after slot OP31_SLOT
//   noise_mix   : noise generator mix
//   op_out      : operator output of the current slot
//   slot_out    : operator output with noise substituted in slot OP31_SLOT
//
// Write handshake: busy rises the clk after an accepted write to NOISE_REG and
// stays high until BUSY_CYCLES cen ticks after the commit. A NOISE_REG write
// is accepted only in clks where busy is low; while busy is high (including
// the clk in which it falls) it is dropped and wr_drop is set.
// -----------------------------------------------------------------------------
module jt51_noise_ctrl
    import jt51_pkg::*;
#(
    parameter logic [4:0] OP31_SLOT   = 5'd31,
    parameter logic [7:0] NOISE_REG   = NOISE_REG_ADDR,
    parameter int         BUSY_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        wr_req,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic        wr_drop,
    output logic [4:0]  cycles,
    output logic [4:0]  nfrq,
    output logic        ne,
    output logic        op31_no,
    input  logic [11:0] noise_mix,
    input  logic [13:0] op_out,
    output logic [13:0] slot_out
);

    localparam logic [7:0] HOLD_LOAD = 8'(BUSY_CYCLES - 1);

    noise_state_e state_q, state_d;
    logic [7:0]   data_q,  data_d;
    logic         busy_q,  busy_d;
    logic         drop_q,  drop_d;
    logic         ne_q,    ne_d;
    logic [4:0]   nfrq_q,  nfrq_d;
    logic [4:0]   cycles_q;
    logic         op31_q;
    logic [13:0]  slot_q;

    logic noise_hit;
    logic frame_end;
    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;

    assign noise_hit = wr_req && (wr_addr == NOISE_REG);
    assign frame_end = cen && (cycles_q == LAST_SLOT);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        busy_d   = busy_q;
        drop_d   = drop_q;
        ne_d     = ne_q;
        nfrq_d   = nfrq_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        if (noise_hit && busy_q) begin
            drop_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (noise_hit) begin
                    data_d  = wr_data;
                    busy_d  = 1'b1;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // Commit only at a frame end so the noise generator never
                // sees NFRQ change mid-frame.
                if (frame_end) begin
                    ne_d     = data_q[NE_BIT];
                    nfrq_d   = data_q[NFRQ_MSB:0];
                    tmr_load = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cen) begin
                    if (tmr_zero) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            ne_q    <= 1'b0;
            nfrq_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            ne_q    <= ne_d;
            nfrq_q  <= nfrq_d;
        end
    end

    // Slot-rate path: counter, op31 strobe and noise substitution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= '0;
            op31_q   <= 1'b0;
            slot_q   <= '0;
        end else if (cen) begin
            cycles_q <= cycles_q + 5'd1;
            op31_q   <= (cycles_q == OP31_SLOT);
            slot_q   <= (ne_q && (cycles_q == OP31_SLOT)) ? {noise_mix, 2'b00} : op_out;
        end
    end

    jt51_busy_timer #(
        .W (8)
    ) u_busy_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .dec_i      (tmr_dec),
        .load_val_i (HOLD_LOAD),
        .zero_o     (tmr_zero)
    );

    assign busy     = busy_q;
    assign wr_drop  = drop_q;
    assign cycles   = cycles_q;
    assign nfrq     = nfrq_q;
    assign ne       = ne_q;
    assign op31_no  = op31_q;
    assign slot_out = slot_q;

endmodule

// File: tb/tb_jt51_noise_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jt51_noise_ctrl
// Directed bench for jt51_noise_ctrl. A tick-counting reference model tracks
// the expected outputs; a compare process checks them on every falling clock
// edge, and the directed sequence adds hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_jt51_noise_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        wr_drop;
  logic [4:0]  cycles;
  logic [4:0]  nfrq;
  logic        ne;
  logic        op31_no;
  logic [11:0] noise_mix;
  logic [13:0] op_out;
  logic [13:0] slot_out;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int n_print = 0;
  bit chk_en  = 1'b0;
  int op31_rises = 0;
  logic op31_prev = 1'b0;

  jt51_noise_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .wr_drop   (wr_drop),
    .cycles    (cycles),
    .nfrq      (nfrq),
    .ne        (ne),
    .op31_no   (op31_no),
    .noise_mix (noise_mix),
    .op_out    (op_out),
    .slot_out  (slot_out)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model. Time is measured in cen ticks since reset: the slot index
  // is tick mod 32, a commit happens on the tick that leaves slot 31, and busy
  // drops 32 ticks after the commit tick.
  // ---------------------------------------------------------------------------
  int          m_tick;
  int          m_fall;
  bit          m_pend;
  bit          m_busy;
  bit          m_drop;
  bit          m_ne;
  bit          m_op31;
  logic [7:0]  m_pdata;
  logic [4:0]  m_nfrq;
  logic [13:0] m_slot;
  bit          m_old_busy;
  bit          m_hit;
  int          m_prev_slot;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tick  = 0;
      m_fall  = 0;
      m_pend  = 1'b0;
      m_busy  = 1'b0;
      m_drop  = 1'b0;
      m_ne    = 1'b0;
      m_op31  = 1'b0;
      m_pdata = '0;
      m_nfrq  = '0;
      m_slot  = '0;
    end else begin
      m_old_busy = m_busy;
      m_hit      = wr_req && (wr_addr == 8'h0F);
      if (cen) begin
        m_prev_slot = m_tick % 32;
        m_slot      = (m_ne && m_prev_slot == 31) ? {noise_mix, 2'b00} : op_out;
        m_op31      = (m_prev_slot == 31);
        m_tick      = m_tick + 1;
        if (m_pend && m_prev_slot == 31) begin
          m_ne   = m_pdata[7];
          m_nfrq = m_pdata[4:0];
          m_pend = 1'b0;
          m_fall = m_tick + 32;
        end else if (m_busy && !m_pend && m_tick == m_fall) begin
          m_busy = 1'b0;
        end
      end
      if (m_hit) begin
        if (m_old_busy) begin
          m_drop = 1'b1;
        end else begin
          m_pend  = 1'b1;
          m_pdata = wr_data;
          m_busy  = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      if (n_print < 40) begin
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        n_print++;
      end
    end else begin
      n_pass++;
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_cycles",   32'(cycles),   32'(m_tick % 32));
      check("m_busy",     32'(busy),     32'(m_busy));
      check("m_wr_drop",  32'(wr_drop),  32'(m_drop));
      check("m_ne",       32'(ne),       32'(m_ne));
      check("m_nfrq",     32'(nfrq),     32'(m_nfrq));
      check("m_op31_no",  32'(op31_no),  32'(m_op31));
      check("m_slot_out", 32'(slot_out), 32'(m_slot));
      if (op31_no && !op31_prev) op31_rises++;
      op31_prev = op31_no;
    end
  end

  // driver tasks
  task automatic run_cen(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2; cen = 1'b1;
      @(posedge clk); #2; cen = 1'b0;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk); #2;
    wr_req  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cen       = 1'b0;
    wr_req    = 1'b0;
    wr_addr   = 8'h00;
    wr_data   = 8'h00;
    noise_mix = 12'hABC;
    op_out    = 14'h2001;
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;

    // reset state
    check("rst_cycles",   32'(cycles),   32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_slot_out", 32'(slot_out), 32'd0);
    check("rst_op31_no",  32'(op31_no),  32'd0);

    // counting: 70 ticks -> two wraps, two op31 strobes
    @(posedge clk); #2; rst_n = 1'b1;
    op31_rises = 0;
    run_cen(35);
    op_out = 14'h1234;
    run_cen(35);
    check("cnt_cycles_70",  32'(cycles),   32'd6);
    check("cnt_op31_rises", 32'(op31_rises), 32'd2);
    check("cnt_slot_out",   32'(slot_out), 32'h1234);

    // commit timing
    run_cen(31);
    check("cmt_cycles_5", 32'(cycles), 32'd5);
    wr(8'h0F, 8'h8A);
    check("cmt_busy_up", 32'(busy), 32'd1);
    run_cen(26);
    check("cmt_cycles_31", 32'(cycles), 32'd31);
    check("cmt_ne_before",   32'(ne),   32'd0);
    check("cmt_nfrq_before", 32'(nfrq), 32'd0);
    run_cen(1);
    check("cmt_ne_after",   32'(ne),   32'd1);
    check("cmt_nfrq_after", 32'(nfrq), 32'd10);

    // drop while busy
    run_cen(10);
    wr(8'h0F, 8'h03);
    check("drop_flag", 32'(wr_drop), 32'd1);
    check("drop_ne",   32'(ne),      32'd1);
    check("drop_nfrq", 32'(nfrq),    32'd10);
    run_cen(21);
    check("drop_busy_hold", 32'(busy), 32'd1);

    // write in the clk busy falls (dropped), then one clk later (accepted)
    @(posedge clk); #2;
    cen = 1'b1; wr_req = 1'b1; wr_addr = 8'h0F; wr_data = 8'h8F;
    @(posedge clk); #2;
    cen = 1'b0; wr_data = 8'h03;
    check("fall_busy_low", 32'(busy),    32'd0);
    check("fall_drop",     32'(wr_drop), 32'd1);
    @(posedge clk); #2;
    wr_req = 1'b0;
    check("fall_accept_busy", 32'(busy), 32'd1);
    run_cen(32);
    check("acc_ne",   32'(ne),   32'd0);
    check("acc_nfrq", 32'(nfrq), 32'd3);
    run_cen(32);
    check("acc_busy_low", 32'(busy), 32'd0);

    // non-noise address
    wr(8'h08, 8'hFF);
    check("nn_busy", 32'(busy),    32'd0);
    check("nn_ne",   32'(ne),      32'd0);
    check("nn_nfrq", 32'(nfrq),    32'd3);
    check("nn_drop", 32'(wr_drop), 32'd1);

    // substitution (bits 6:5 of the data ignored)
    wr(8'h0F, 8'hE5);
    run_cen(63);
    check("sub_ne",    32'(ne),       32'd1);
    check("sub_nfrq",  32'(nfrq),     32'd5);
    check("sub_pre",   32'(slot_out), 32'h1234);
    run_cen(1);
    check("sub_noise", 32'(slot_out), 32'h2AF0);
    check("sub_op31",  32'(op31_no),  32'd1);
    run_cen(1);
    check("sub_post",  32'(slot_out), 32'h1234);
    check("sub_busy",  32'(busy),     32'd0);

    // reset mid-PEND
    wr(8'h0F, 8'h9F);
    run_cen(19);
    check("rp_cycles_20", 32'(cycles), 32'd20);
    check("rp_busy",      32'(busy),   32'd1);
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    check("rp_async_cycles", 32'(cycles),   32'd0);
    check("rp_async_busy",   32'(busy),     32'd0);
    check("rp_async_ne",     32'(ne),       32'd0);
    check("rp_async_nfrq",   32'(nfrq),     32'd0);
    check("rp_async_drop",   32'(wr_drop),  32'd0);
    check("rp_async_slot",   32'(slot_out), 32'd0);
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b1;
    run_cen(40);
    check("rp_no_commit_ne",   32'(ne),     32'd0);
    check("rp_no_commit_nfrq", 32'(nfrq),   32'd0);
    check("rp_busy_low",       32'(busy),   32'd0);
    check("rp_cycles_8",       32'(cycles), 32'd8);

    @(posedge clk); #2;
    chk_en = 1'b0;
    if (n_fail == 0)
      $display("PASS: %0d failures, %0d/%0d checks passed", n_fail, n_pass, n_total);
    else
      $display("FAIL: %0d failures, %0d/%0d checks passed", n_fail, n_pass, n_total);
    $finish;
  end

endmodule
